pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 98 +++++++++
 tb/tb_pipe_skid_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register stage with valid/ready handshake on both sides.
// Registered outputs, flush kill and synchronous active-low reset.
module pipe_skid_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_nxt;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_nxt;
  logic             accept;
  logic             pop;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = (state != FULL) & reset;
  assign occupancy = state;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Next state and data: main always heads the queue, skid holds the overflow.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          main_nxt  = in_data;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_nxt = in_data;
        end else if (accept) begin
          skid_nxt  = in_data;
          state_nxt = FULL;
        end else if (pop) begin
          main_nxt  = RESET_VAL;
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_nxt  = skid_q;
          skid_nxt  = RESET_VAL;
          state_nxt = ONE;
        end
      end
      default: begin
        main_nxt  = RESET_VAL;
        skid_nxt  = RESET_VAL;
        state_nxt = EMPTY;
      end
    endcase
    if (flush) begin
      main_nxt  = RESET_VAL;
      skid_nxt  = RESET_VAL;
      state_nxt = EMPTY;
    end
  end

  // State and payload registers; reset wins over flush and handshakes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios on a 32-bit instance and a
// random valid/ready run on an 8-bit instance, both checked by a queue model.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        sel;

  logic        r32_in_ready, r32_out_valid;
  logic [31:0] r32_out_data;
  logic [1:0]  r32_occ;
  logic        r8_in_ready, r8_out_valid;
  logic [7:0]  r8_out_data;
  logic [1:0]  r8_occ;

  logic        o_in_ready, o_out_valid;
  logic [31:0] o_data;
  logic [1:0]  o_occ;

  logic [31:0] q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (r32_in_ready),
    .out_valid (r32_out_valid),
    .out_data  (r32_out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (r32_occ)
  );

  pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'hFF)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data[7:0]),
    .in_ready  (r8_in_ready),
    .out_valid (r8_out_valid),
    .out_data  (r8_out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (r8_occ)
  );

  assign o_in_ready  = sel ? r8_in_ready : r32_in_ready;
  assign o_out_valid = sel ? r8_out_valid : r32_out_valid;
  assign o_data      = sel ? {24'h0, r8_out_data} : r32_out_data;
  assign o_occ       = sel ? r8_occ : r32_occ;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rv();
    return sel ? 32'h0000_00FF : 32'h0;
  endfunction

  task automatic check_model();
    int n;
    n = q.size();
    chk("occupancy", {30'h0, o_occ}, n);
    chk("in_ready", {31'h0, o_in_ready}, {31'h0, (n < 2) && reset});
    chk("out_valid", {31'h0, o_out_valid}, {31'h0, n != 0});
    chk("out_data", o_data, (n != 0) ? q[0] : rv());
  endtask

  task automatic step();
    bit acc, pp;
    acc = reset && in_valid && (q.size() < 2);
    pp  = reset && out_ready && (q.size() > 0);
    @(posedge clk);
    if (!reset || flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(sel ? {24'h0, in_data[7:0]} : in_data);
    end
    #1;
    check_model();
  endtask

  initial begin
    sel       = 1'b0;
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    step();
    chk("rst_in_ready", {31'h0, o_in_ready}, 32'h0);
    chk("rst_data", o_data, 32'h0);

    flush    = 1'b0;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rel_in_ready", {31'h0, o_in_ready}, 32'h1);

    // streaming
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = i;
      step();
      chk("stream_data", o_data, i);
      chk("stream_occ", {30'h0, o_occ}, 32'd1);
      chk("stream_rdy", {31'h0, o_in_ready}, 32'h1);
    end
    in_valid = 1'b0;
    step();

    // backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_0001;
    step();
    in_data   = 32'hBBBB_0002;
    step();
    chk("bp_occ", {30'h0, o_occ}, 32'd2);
    chk("bp_rdy", {31'h0, o_in_ready}, 32'h0);
    chk("bp_data", o_data, 32'hAAAA_0001);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_pop_b", o_data, 32'hBBBB_0002);
    step();
    chk("bp_empty", {30'h0, o_occ}, 32'd0);

    // flush in FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_0001;
    step();
    in_data   = 32'hBBBB_0002;
    step();
    in_data   = 32'hCCCC_0003;
    flush     = 1'b1;
    step();
    chk("fl_occ", {30'h0, o_occ}, 32'd0);
    chk("fl_valid", {31'h0, o_out_valid}, 32'h0);
    chk("fl_data", o_data, 32'h0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    // flush in ONE drops the payload handshaken on the same edge
    in_valid = 1'b1;
    in_data  = 32'h1111_0001;
    step();
    in_data  = 32'hCCCC_0004;
    flush    = 1'b1;
    step();
    chk("fl1_occ", {30'h0, o_occ}, 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();

    // reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    step();
    chk("mr_hold", o_data, 32'h1234_5678);
    in_valid  = 1'b0;
    reset     = 1'b0;
    #1;
    chk("mr_rdy_low", {31'h0, o_in_ready}, 32'h0);
    step();
    chk("mr_occ", {30'h0, o_occ}, 32'd0);
    chk("mr_data", o_data, 32'h0);
    reset = 1'b1;
    #1;
    chk("mr_rdy_rel", {31'h0, o_in_ready}, 32'h1);

    // accept and pop together in ONE
    in_valid = 1'b1;
    in_data  = 32'h0000_00A5;
    step();
    in_data   = 32'h0000_D00D;
    out_ready = 1'b1;
    step();
    chk("sim_data", o_data, 32'h0000_D00D);
    chk("sim_occ", {30'h0, o_occ}, 32'd1);
    in_valid = 1'b0;
    step();

    // random traffic on the 8-bit instance
    sel   = 1'b1;
    reset = 1'b0;
    step();
    chk("r8_rst_data", o_data, 32'hFF);
    reset = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("r8_drained", {30'h0, o_occ}, 32'd0);
    chk("r8_idle", o_data, 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
